// File: rtl/dm_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dm_arbiter
// Brief    : Two-port arbiter in front of a single-port 4 KB data memory.
//            One access per grant cycle, round-robin or fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
module dm_arbiter #(
    parameter int PRIO_MODE    = 0,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [11:2] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_ack,
    output logic [31:0] p0_rdata,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [11:2] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_ack,
    output logic [31:0] p1_rdata,
    output logic        dm_we,
    output logic [11:2] dm_addr,
    output logic [31:0] dm_din,
    input  logic [31:0] dm_dout,
    output logic        busy
);

    localparam logic [3:0] c_STARVE_MAX = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_last_served;
    logic [3:0]  r_starve_cnt;
    logic        r_p0_ack;
    logic        r_p1_ack;
    logic [31:0] r_p0_rdata;
    logic [31:0] r_p1_rdata;
    logic        w_elig0;
    logic        w_elig1;

    // A port still showing its ack has just been served and must not win again.
    assign w_elig0 = p0_req & ~r_p0_ack;
    assign w_elig1 = p1_req & ~r_p1_ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_last_served <= 1'b1;
            r_starve_cnt  <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt == GNT0) begin
                r_last_served <= 1'b0;
                if (w_elig1 && (r_starve_cnt != c_STARVE_MAX)) begin
                    r_starve_cnt <= r_starve_cnt + 4'd1;
                end
            end else if (w_state_nxt == GNT1) begin
                r_last_served <= 1'b1;
                r_starve_cnt  <= 4'd0;
            end
        end
    end

    always_comb begin
        w_state_nxt = IDLE;
        dm_we       = 1'b0;
        dm_addr     = '0;
        dm_din      = '0;
        case (r_state)
            IDLE: begin
                if (w_elig0 && w_elig1) begin
                    if (PRIO_MODE == 0) begin
                        w_state_nxt = r_last_served ? GNT0 : GNT1;
                    end else begin
                        w_state_nxt = (r_starve_cnt == c_STARVE_MAX) ? GNT1 : GNT0;
                    end
                end else if (w_elig0) begin
                    w_state_nxt = GNT0;
                end else if (w_elig1) begin
                    w_state_nxt = GNT1;
                end
            end
            GNT0: begin
                dm_we   = p0_we;
                dm_addr = p0_addr;
                dm_din  = p0_wdata;
            end
            GNT1: begin
                dm_we   = p1_we;
                dm_addr = p1_addr;
                dm_din  = p1_wdata;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Completion: ack pulses after the grant cycle; reads capture memory data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p0_ack   <= 1'b0;
            r_p1_ack   <= 1'b0;
            r_p0_rdata <= 32'd0;
            r_p1_rdata <= 32'd0;
        end else begin
            r_p0_ack <= (r_state == GNT0);
            r_p1_ack <= (r_state == GNT1);
            if ((r_state == GNT0) && !p0_we) begin
                r_p0_rdata <= dm_dout;
            end
            if ((r_state == GNT1) && !p1_we) begin
                r_p1_rdata <= dm_dout;
            end
        end
    end

    assign p0_ack   = r_p0_ack;
    assign p1_ack   = r_p1_ack;
    assign p0_rdata = r_p0_rdata;
    assign p1_rdata = r_p1_rdata;
    assign busy     = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dm_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dm_arbiter
// Brief    : Scoreboard bench for dm_arbiter: a round-robin instance (a_*)
//            and a fixed-priority instance with STARVE_LIMIT=2 (b_*).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dm_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [11:2] p0_addr, p1_addr;
    logic [31:0] p0_wdata, p1_wdata;

    logic        a_p0_ack, a_p1_ack, a_dm_we, a_busy;
    logic [31:0] a_p0_rdata, a_p1_rdata, a_dm_din, a_dm_dout;
    logic [11:2] a_dm_addr;
    logic        b_p0_ack, b_p1_ack, b_dm_we, b_busy;
    logic [31:0] b_p0_rdata, b_p1_rdata, b_dm_din, b_dm_dout;
    logic [11:2] b_dm_addr;

    logic [31:0] mem_a [0:1023];
    logic [31:0] mem_b [0:1023];
    logic        pl_we = 1'b0;
    logic [11:2] pl_addr = '0;
    logic [31:0] pl_data = '0;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          dbl_a   = 0, dbl_b = 0, stray_a = 0, stray_b = 0, we_cnt_a = 0;
    logic [32:0] exp_q [$];
    logic [32:0] obs_a [$];
    logic [32:0] obs_b [$];
    int          cyc_a [$];

    always #5 clk = ~clk;

    dm_arbiter #(.PRIO_MODE(0), .STARVE_LIMIT(4)) dut_rr (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(a_p0_ack), .p0_rdata(a_p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(a_p1_ack), .p1_rdata(a_p1_rdata),
        .dm_we(a_dm_we), .dm_addr(a_dm_addr), .dm_din(a_dm_din), .dm_dout(a_dm_dout),
        .busy(a_busy)
    );

    dm_arbiter #(.PRIO_MODE(1), .STARVE_LIMIT(2)) dut_fx (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(b_p0_ack), .p0_rdata(b_p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(b_p1_ack), .p1_rdata(b_p1_rdata),
        .dm_we(b_dm_we), .dm_addr(b_dm_addr), .dm_din(b_dm_din), .dm_dout(b_dm_dout),
        .busy(b_busy)
    );

    // Memory models; the preload port takes precedence over DUT writes.
    always @(posedge clk) begin
        if (pl_we) begin
            mem_a[pl_addr] <= pl_data;
            mem_b[pl_addr] <= pl_data;
        end else begin
            if (a_dm_we) mem_a[a_dm_addr] <= a_dm_din;
            if (b_dm_we) mem_b[b_dm_addr] <= b_dm_din;
        end
    end
    assign a_dm_dout = mem_a[a_dm_addr];
    assign b_dm_dout = mem_b[b_dm_addr];

    // Output monitor: records every ack as {port, rdata}.
    always @(negedge clk) begin
        cyc++;
        if (a_p0_ack) begin obs_a.push_back({1'b0, a_p0_rdata}); cyc_a.push_back(cyc); end
        if (a_p1_ack) begin obs_a.push_back({1'b1, a_p1_rdata}); cyc_a.push_back(cyc); end
        if (b_p0_ack) obs_b.push_back({1'b0, b_p0_rdata});
        if (b_p1_ack) obs_b.push_back({1'b1, b_p1_rdata});
        if (a_p0_ack && a_p1_ack) dbl_a++;
        if (b_p0_ack && b_p1_ack) dbl_b++;
        if (a_dm_we && !a_busy) stray_a++;
        if (b_dm_we && !b_busy) stray_b++;
        if (a_dm_we) we_cnt_a++;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_idle();
        p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
    endtask

    task automatic poke(input logic [11:2] addr, input logic [31:0] data);
        pl_addr = addr; pl_data = data; pl_we = 1'b1;
        tick();
        pl_we = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        set_idle();
        tick();
        tick();
        rst = 1'b0;
        obs_a.delete(); obs_b.delete(); cyc_a.delete(); exp_q.delete();
    endtask

    task automatic access(input bit port, input bit we, input logic [11:2] addr,
                          input logic [31:0] wdata, output bit ok);
        ok = 1'b0;
        if (port == 1'b0) begin
            p0_we = we; p0_addr = addr; p0_wdata = wdata; p0_req = 1'b1;
        end else begin
            p1_we = we; p1_addr = addr; p1_wdata = wdata; p1_req = 1'b1;
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            if ((port == 1'b0 && a_p0_ack) || (port == 1'b1 && a_p1_ack)) begin
                ok = 1'b1;
                break;
            end
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_idle();
        #1;
        n_tests++;
        if ({a_busy, a_p0_ack, a_p1_ack, a_dm_we} !== 4'b0) begin
            n_fail++; $display("FAIL rst_ctrl_a: busy/ack0/ack1/we=%b, expected 0000", {a_busy, a_p0_ack, a_p1_ack, a_dm_we});
        end
        n_tests++;
        if ({a_p0_rdata, a_p1_rdata} !== 64'd0) begin
            n_fail++; $display("FAIL rst_rdata_a: %h %h, expected 0 0", a_p0_rdata, a_p1_rdata);
        end
        n_tests++;
        if ({a_dm_addr, a_dm_din} !== 42'd0) begin
            n_fail++; $display("FAIL rst_dm_a: addr %h din %h, expected 0 0", a_dm_addr, a_dm_din);
        end
        n_tests++;
        if ({b_busy, b_p0_ack, b_p1_ack, b_dm_we} !== 4'b0) begin
            n_fail++; $display("FAIL rst_ctrl_b: busy/ack0/ack1/we=%b, expected 0000", {b_busy, b_p0_ack, b_p1_ack, b_dm_we});
        end
        n_tests++;
        if ({b_p0_rdata, b_p1_rdata} !== 64'd0) begin
            n_fail++; $display("FAIL rst_rdata_b: %h %h, expected 0 0", b_p0_rdata, b_p1_rdata);
        end
        poke(10'h010, 32'hDEADBEEF);
        poke(10'h000, 32'h5A5A0000);
        poke(10'h3FF, 32'h00000000);
        poke(10'h001, 32'h11111111);
        poke(10'h002, 32'h22222222);
        poke(10'h020, 32'h0BADF00D);
        tick();
        rst = 1'b0;
        obs_a.delete(); obs_b.delete(); cyc_a.delete(); exp_q.delete();
    endtask

    task automatic test_single_read();
        logic [32:0] e, o;
        int we0;
        we0 = we_cnt_a;
        p0_we = 1'b0; p0_addr = 10'h010; p0_req = 1'b1;
        exp_q.push_back({1'b0, 32'hDEADBEEF});
        tick();
        n_tests++;
        if (a_busy !== 1'b1 || a_dm_addr !== 10'h010) begin
            n_fail++; $display("FAIL rd_grant: busy %b addr %h, expected 1 010", a_busy, a_dm_addr);
        end
        tick();
        n_tests++;
        if (a_p0_ack !== 1'b1 || a_p0_rdata !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL rd_latency: ack %b rdata %h, expected 1 deadbeef", a_p0_ack, a_p0_rdata);
        end
        p0_req = 1'b0;
        tick();
        tick();
        n_tests++;
        if (we_cnt_a != we0) begin
            n_fail++; $display("FAIL rd_no_write: %0d write cycles, expected 0", we_cnt_a - we0);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (obs_a.size() == 0) begin
                n_fail++; $display("FAIL rd_sb: no ack, expected port %0d data %h", e[32], e[31:0]);
            end else begin
                o = obs_a.pop_front();
                if (o !== e) begin
                    n_fail++; $display("FAIL rd_sb: port %0d data %h, expected port %0d data %h", o[32], o[31:0], e[32], e[31:0]);
                end
            end
        end
        n_tests++;
        if (obs_a.size() != 0) begin
            n_fail++; $display("FAIL rd_extra: %0d extra acks, expected 0", obs_a.size());
        end
    endtask

    task automatic test_write_read();
        logic [32:0] e, o;
        bit ok;
        exp_q.push_back({1'b1, 32'h00000000});
        access(1'b1, 1'b1, 10'h3FF, 32'h12345678, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL wr_timeout: ack 0, expected 1"); end
        tick();
        n_tests++;
        if (mem_a[10'h3FF] !== 32'h12345678) begin
            n_fail++; $display("FAIL wr_commit: mem[3ff]=%h, expected 12345678", mem_a[10'h3FF]);
        end
        exp_q.push_back({1'b1, 32'h12345678});
        access(1'b1, 1'b0, 10'h3FF, 32'h0, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL rdback_timeout: ack 0, expected 1"); end
        tick();
        n_tests++;
        if (mem_a[10'h000] !== 32'h5A5A0000) begin
            n_fail++; $display("FAIL wr_wrap: mem[000]=%h, expected 5a5a0000", mem_a[10'h000]);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (obs_a.size() == 0) begin
                n_fail++; $display("FAIL wr_sb: no ack, expected port %0d data %h", e[32], e[31:0]);
            end else begin
                o = obs_a.pop_front();
                if (o !== e) begin
                    n_fail++; $display("FAIL wr_sb: port %0d data %h, expected port %0d data %h", o[32], o[31:0], e[32], e[31:0]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [32:0] e, o;
        bit gaps_ok;
        apply_reset();
        p0_we = 1'b0; p0_addr = 10'h001;
        p1_we = 1'b0; p1_addr = 10'h002;
        for (int k = 0; k < 6; k++) begin
            exp_q.push_back((k % 2 == 0) ? {1'b0, 32'h11111111} : {1'b1, 32'h22222222});
        end
        p0_req = 1'b1; p1_req = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (obs_a.size() >= 6) break;
        end
        p0_req = 1'b0; p1_req = 1'b0;
        tick(); tick(); tick();
        gaps_ok = (cyc_a.size() >= 6);
        for (int k = 1; k < cyc_a.size(); k++) begin
            if (cyc_a[k] - cyc_a[k-1] != 2) gaps_ok = 1'b0;
        end
        n_tests++;
        if (!gaps_ok) begin
            n_fail++; $display("FAIL b2b_rate: %0d acks not 2 cycles apart, expected 6 at 2-cycle spacing", cyc_a.size());
        end
        n_tests++;
        if (dbl_a != 0) begin n_fail++; $display("FAIL b2b_dbl_ack: %0d cycles, expected 0", dbl_a); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (obs_a.size() == 0) begin
                n_fail++; $display("FAIL rr_order: no ack, expected port %0d data %h", e[32], e[31:0]);
            end else begin
                o = obs_a.pop_front();
                if (o !== e) begin
                    n_fail++; $display("FAIL rr_order: port %0d data %h, expected port %0d data %h", o[32], o[31:0], e[32], e[31:0]);
                end
            end
        end
        n_tests++;
        if (obs_a.size() != 0) begin
            n_fail++; $display("FAIL rr_extra: %0d extra acks, expected 0", obs_a.size());
        end
    endtask

    task automatic test_starvation();
        logic [32:0] e, o;
        apply_reset();
        p0_we = 1'b0; p0_addr = 10'h001;
        p1_we = 1'b0; p1_addr = 10'h002;
        exp_q.push_back({1'b0, 32'h11111111});
        exp_q.push_back({1'b0, 32'h11111111});
        exp_q.push_back({1'b1, 32'h22222222});
        exp_q.push_back({1'b0, 32'h11111111});
        exp_q.push_back({1'b0, 32'h11111111});
        exp_q.push_back({1'b1, 32'h22222222});
        // Each requester steps back while the other is acked, so every
        // re-arbitration is a genuine tie and port 1 keeps losing until forced.
        for (int i = 0; i < 60; i++) begin
            p0_req = !b_p1_ack;
            p1_req = !b_p0_ack;
            if (obs_b.size() >= 6) break;
            tick();
        end
        p0_req = 1'b0; p1_req = 1'b0;
        tick(); tick(); tick();
        n_tests++;
        if (dbl_b != 0) begin n_fail++; $display("FAIL fx_dbl_ack: %0d cycles, expected 0", dbl_b); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (obs_b.size() == 0) begin
                n_fail++; $display("FAIL fx_order: no ack, expected port %0d data %h", e[32], e[31:0]);
            end else begin
                o = obs_b.pop_front();
                if (o !== e) begin
                    n_fail++; $display("FAIL fx_order: port %0d data %h, expected port %0d data %h", o[32], o[31:0], e[32], e[31:0]);
                end
            end
        end
        n_tests++;
        if (obs_b.size() != 0) begin
            n_fail++; $display("FAIL fx_extra: %0d extra acks, expected 0", obs_b.size());
        end
    endtask

    task automatic test_reset_mid_write();
        bit ok;
        apply_reset();
        access(1'b0, 1'b0, 10'h010, 32'h0, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL mw_setup: ack 0, expected 1"); end
        tick();
        obs_a.delete();
        p0_we = 1'b1; p0_addr = 10'h020; p0_wdata = 32'hAAAAAAAA; p0_req = 1'b1;
        tick();
        n_tests++;
        if (a_busy !== 1'b1 || a_dm_we !== 1'b1) begin
            n_fail++; $display("FAIL mw_grant: busy %b we %b, expected 1 1", a_busy, a_dm_we);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if (a_busy !== 1'b0 || a_dm_we !== 1'b0 || a_p0_rdata !== 32'd0) begin
            n_fail++; $display("FAIL mw_async: busy %b we %b rdata %h, expected 0 0 0", a_busy, a_dm_we, a_p0_rdata);
        end
        p0_req = 1'b0; p0_we = 1'b0;
        tick();
        tick();
        n_tests++;
        if (mem_a[10'h020] !== 32'h0BADF00D) begin
            n_fail++; $display("FAIL mw_suppress: mem[020]=%h, expected 0badf00d", mem_a[10'h020]);
        end
        n_tests++;
        if (obs_a.size() != 0) begin
            n_fail++; $display("FAIL mw_no_ack: %0d acks, expected 0", obs_a.size());
        end
    endtask

    task automatic test_withdrawn();
        logic [32:0] e, o;
        rst = 1'b1;
        set_idle();
        p0_we = 1'b0; p0_addr = 10'h010; p0_req = 1'b1;
        tick();
        rst = 1'b0;
        obs_a.delete(); exp_q.delete();
        exp_q.push_back({1'b0, 32'hDEADBEEF});
        tick();
        n_tests++;
        if (a_busy !== 1'b1 || a_dm_addr !== 10'h010) begin
            n_fail++; $display("FAIL wd_first_edge: busy %b addr %h, expected 1 010", a_busy, a_dm_addr);
        end
        p1_we = 1'b1; p1_addr = 10'h3FF; p1_wdata = 32'hFFFFFFFF; p1_req = 1'b1;
        tick();
        p0_req = 1'b0; p1_req = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        n_tests++;
        if (mem_a[10'h3FF] !== 32'h12345678) begin
            n_fail++; $display("FAIL wd_no_write: mem[3ff]=%h, expected 12345678", mem_a[10'h3FF]);
        end
        n_tests++;
        if (stray_a != 0 || stray_b != 0) begin
            n_fail++; $display("FAIL dm_we_idle: %0d/%0d cycles, expected 0/0", stray_a, stray_b);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (obs_a.size() == 0) begin
                n_fail++; $display("FAIL wd_sb: no ack, expected port %0d data %h", e[32], e[31:0]);
            end else begin
                o = obs_a.pop_front();
                if (o !== e) begin
                    n_fail++; $display("FAIL wd_sb: port %0d data %h, expected port %0d data %h", o[32], o[31:0], e[32], e[31:0]);
                end
            end
        end
        n_tests++;
        if (obs_a.size() != 0) begin
            n_fail++; $display("FAIL wd_p1_acked: %0d extra acks, expected 0", obs_a.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write_read();
        test_back_to_back();
        test_starvation();
        test_reset_mid_write();
        test_withdrawn();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
